// File: rtl/clock_set_if.sv
// Bus between the set-mode controller and its environment: buttons, blink tick,
// timer value/load interface and display blanking.
interface clock_set_if;
    localparam int unsigned BCD_W   = 16;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned STATE_W = 2;

    logic               tick_blink;
    logic               btn_mode;
    logic               btn_inc;
    logic [BCD_W-1:0]   cur_bcd;
    logic               run_en;
    logic               load;
    logic [BCD_W-1:0]   load_bcd;
    logic [DIGITS-1:0]  digit_blank;
    logic [STATE_W-1:0] mode_state;

    modport master (
        input  tick_blink, btn_mode, btn_inc, cur_bcd,
        output run_en, load, load_bcd, digit_blank, mode_state
    );

    modport slave (
        output tick_blink, btn_mode, btn_inc, cur_bcd,
        input  run_en, load, load_bcd, digit_blank, mode_state
    );
endinterface

// File: rtl/clock_set_controller.sv
// Run/set/commit mode controller for the MM:SS timer: stops the timer, edits
// minutes and seconds with blink and auto-repeat, then loads the edited value back.
module clock_set_controller #(
    parameter int unsigned REPEAT_DELAY = 4
) (
    input logic         clock,
    input logic         reset,
    clock_set_if.master bus
);
    localparam int unsigned BCD_W   = 16;
    localparam int unsigned FIELD_W = 8;
    localparam int unsigned HOLD_W  = 4;
    localparam int unsigned DIGITS  = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_MIN = 2'd1,
        SET_SEC = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                mode_q;
    logic                inc_q;
    logic [BCD_W-1:0]    edit_q;
    logic [BCD_W-1:0]    edit_nxt;
    logic                blink_q;
    logic                blink_nxt;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_nxt;
    logic [HOLD_W-1:0]   hold_step;

    logic                mode_pe;
    logic                inc_pe;
    logic                hold_sat;
    logic                repeat_step;
    logic                do_inc;
    logic                run_en;
    logic                load;
    logic [DIGITS-1:0]   digit_blank;

    // Two-digit BCD increment wrapping 59 -> 00; out-of-range digits fold back on rollover.
    function automatic logic [FIELD_W-1:0] bcd_inc(input logic [FIELD_W-1:0] field);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = field[7:4];
        ones = field[3:0];
        if (ones >= 4'd9) begin
            ones = 4'd0;
            tens = (tens >= 4'd5) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    // Previous levels reset high so a button held through reset does not fire.
    assign mode_pe = bus.btn_mode & ~mode_q;
    assign inc_pe  = bus.btn_inc  & ~inc_q;

    assign hold_sat    = (hold_q == HOLD_W'(REPEAT_DELAY));
    assign repeat_step = bus.tick_blink & bus.btn_inc & hold_sat;
    assign do_inc      = inc_pe | repeat_step;

    // Hold counter advance while the increment button stays down in a set state.
    always_comb begin
        hold_step = '0;
        if (bus.btn_inc) begin
            if (bus.tick_blink && !hold_sat) begin
                hold_step = hold_q + HOLD_W'(1);
            end else begin
                hold_step = hold_q;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            mode_q  <= 1'b1;
            inc_q   <= 1'b1;
            edit_q  <= '0;
            blink_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state   <= state_nxt;
            mode_q  <= bus.btn_mode;
            inc_q   <= bus.btn_inc;
            edit_q  <= edit_nxt;
            blink_q <= blink_nxt;
            hold_q  <= hold_nxt;
        end
    end

    // Next state, edit datapath and decoded outputs; a mode edge always beats an increment.
    always_comb begin
        state_nxt   = state;
        edit_nxt    = edit_q;
        blink_nxt   = 1'b0;
        hold_nxt    = '0;
        run_en      = 1'b0;
        load        = 1'b0;
        digit_blank = '0;

        case (state)
            RUN: begin
                run_en = 1'b1;
                if (mode_pe) begin
                    edit_nxt  = bus.cur_bcd;
                    state_nxt = SET_MIN;
                end
            end
            SET_MIN: begin
                digit_blank = {blink_q, blink_q, 2'b00};
                if (mode_pe) begin
                    state_nxt = SET_SEC;
                end else begin
                    blink_nxt = blink_q ^ bus.tick_blink;
                    hold_nxt  = hold_step;
                    if (do_inc) begin
                        edit_nxt[15:8] = bcd_inc(edit_q[15:8]);
                    end
                end
            end
            SET_SEC: begin
                digit_blank = {2'b00, blink_q, blink_q};
                if (mode_pe) begin
                    state_nxt = COMMIT;
                end else begin
                    blink_nxt = blink_q ^ bus.tick_blink;
                    hold_nxt  = hold_step;
                    if (do_inc) begin
                        edit_nxt[7:0] = bcd_inc(edit_q[7:0]);
                    end
                end
            end
            COMMIT: begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign bus.run_en      = run_en;
    assign bus.load        = load;
    assign bus.load_bcd    = edit_q;
    assign bus.digit_blank = digit_blank;
    assign bus.mode_state  = state;

endmodule
